// File: rtl/vga_frame_engine.sv
// VGA timing, ping-pong framebuffer with frame-synchronous swap, integer upscaling and colour expansion.
// Syncs/RGB lag the counter tick by 2 clk, writes land in 1 clk; no backpressure, in-range writes always accepted.
module vga_frame_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter int SCALE    = 2,
  parameter int PIX_FMT  = 0,
  parameter int SYNC_POL = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [9:0]                     wr_x,
  input  logic [9:0]                     wr_y,
  input  logic [(PIX_FMT ? 12 : 8)-1:0]  wr_data,
  input  logic                           swap_req,
  output logic                           swap_ack,
  output logic                           frame_start,
  output logic [9:0]                     hc,
  output logic [9:0]                     vc,
  output logic                           hsync,
  output logic                           vsync,
  output logic [3:0]                     red,
  output logic [3:0]                     green,
  output logic [3:0]                     blue
);
  localparam int DW      = PIX_FMT ? 12 : 8;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SH      = (SCALE == 4) ? 2 : ((SCALE == 2) ? 1 : 0);
  localparam int FB_W    = H_ACTIVE / SCALE;
  localparam int FB_H    = V_ACTIVE / SCALE;
  localparam int DEPTH   = FB_W * FB_H;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X_LIM    = 10'(FB_W);
  localparam logic [9:0] Y_LIM    = 10'(FB_H);
  localparam logic       SYNC_ON  = (SYNC_POL != 0);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_WAIT_DROP} swap_state_e;

  swap_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hc_q, hc_d, vc_q, vc_d;
  logic             frame_start_q, frame_start_d;
  logic             front_q, front_d, swap_ack_q, swap_ack_d;
  logic             act_p1_q, act_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic [11:0]      rgb_q, rgb_d, col;
  logic [DW-1:0]    mem_rd_q, mem_rd_d;
  logic [DW-1:0]    mem0 [DEPTH];
  logic [DW-1:0]    mem1 [DEPTH];
  logic             tick, active, wr_ok, swap_tick;
  logic [AW-1:0]    rd_addr, wr_addr;

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
    hc_d  = hc_q;
    vc_d  = vc_q;
    if (tick) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
    frame_start_d = tick && (hc_d == '0) && (vc_d == '0);

    // Blanking reads are parked at address 0; their data is masked downstream anyway.
    active  = (hc_q < H_ACT) && (vc_q < V_ACT);
    rd_addr = '0;
    if (active) rd_addr = AW'(int'(vc_q >> SH) * FB_W + int'(hc_q >> SH));
    mem_rd_d = front_q ? mem1[rd_addr] : mem0[rd_addr];
    wr_ok    = wr_en && (wr_x < X_LIM) && (wr_y < Y_LIM);
    wr_addr  = AW'(int'(wr_y) * FB_W + int'(wr_x));

    act_p1_d = active;
    hs_p1_d  = (hc_q >= HS_START) && (hc_q < HS_END);
    vs_p1_d  = (vc_q >= VS_START) && (vc_q < VS_END);
    hsync_d  = hs_p1_q ? SYNC_ON : ~SYNC_ON;
    vsync_d  = vs_p1_q ? SYNC_ON : ~SYNC_ON;
    rgb_d    = act_p1_q ? col : 12'h000;
  end

  always_comb begin
    state_d    = state_q;
    front_d    = front_q;
    swap_ack_d = 1'b0;
    swap_tick  = tick && (hc_q == '0) && (vc_q == V_ACT);
    case (state_q)
      S_IDLE:    if (swap_req) state_d = S_PENDING;
      S_PENDING: if (swap_tick) begin
        front_d    = ~front_q;
        swap_ack_d = 1'b1;
        state_d    = S_WAIT_DROP;
      end
      S_WAIT_DROP: if (!swap_req) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      div_q         <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      frame_start_q <= 1'b0;
      front_q       <= 1'b0;
      swap_ack_q    <= 1'b0;
      act_p1_q      <= 1'b0;
      hs_p1_q       <= 1'b0;
      vs_p1_q       <= 1'b0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_start_q <= frame_start_d;
      front_q       <= front_d;
      swap_ack_q    <= swap_ack_d;
      act_p1_q      <= act_p1_d;
      hs_p1_q       <= hs_p1_d;
      vs_p1_q       <= vs_p1_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
    end
  end

  // Write bank uses the pre-edge front, so a write on the toggle clk hits the old back buffer.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (front_q) mem0[wr_addr] <= wr_data;
      else         mem1[wr_addr] <= wr_data;
    end
    mem_rd_q <= mem_rd_d;
  end

  if (PIX_FMT == 0) begin : g_rgb332
    assign col = {mem_rd_q[7:5], mem_rd_q[7], mem_rd_q[4:2], mem_rd_q[4], mem_rd_q[1:0], mem_rd_q[1:0]};
  end else begin : g_rgb444
    assign col = mem_rd_q;
  end

  assign hc          = hc_q;
  assign vc          = vc_q;
  assign frame_start = frame_start_q;
  assign swap_ack    = swap_ack_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];
endmodule

// File: tb/tb_vga_frame_engine.sv
// Directed bench for vga_frame_engine on a shrunken 24x12-tick raster (16x8 visible, sync at hc 18..20, vc 9..10).
// Instance A: SCALE=2, RGB332, active-low syncs, CLK_DIV=2; instance B: SCALE=4, RGB444, active-high, CLK_DIV=3.
module tb_vga_frame_engine;
  localparam int FR_A = 24 * 12 * 2;
  localparam int FR_B = 24 * 12 * 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        wr_en = 1'b0, swap_req = 1'b0;
  logic [9:0]  wr_x = '0, wr_y = '0;
  logic [7:0]  wr_data = '0;
  logic        swap_ack, frame_start, hsync, vsync;
  logic [9:0]  hc, vc;
  logic [3:0]  red, green, blue;

  logic        wr_en_b = 1'b0, swap_req_b = 1'b0;
  logic [9:0]  wr_x_b = '0, wr_y_b = '0;
  logic [11:0] wr_data_b = '0;
  logic        swap_ack_b, frame_start_b, hsync_b, vsync_b;
  logic [9:0]  hc_b, vc_b;
  logic [3:0]  red_b, green_b, blue_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_frame_engine #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .SCALE(2), .PIX_FMT(0), .SYNC_POL(0)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start), .hc(hc), .vc(vc),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
  );

  vga_frame_engine #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(3), .SCALE(4), .PIX_FMT(1), .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_x(wr_x_b), .wr_y(wr_y_b), .wr_data(wr_data_b),
    .swap_req(swap_req_b), .swap_ack(swap_ack_b), .frame_start(frame_start_b), .hc(hc_b), .vc(vc_b),
    .hsync(hsync_b), .vsync(vsync_b), .red(red_b), .green(green_b), .blue(blue_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit b, input int x, input int y, input logic [11:0] d);
    if (b) begin
      wr_en_b = 1'b1; wr_x_b = 10'(x); wr_y_b = 10'(y); wr_data_b = d;
    end else begin
      wr_en = 1'b1; wr_x = 10'(x); wr_y = 10'(y); wr_data = d[7:0];
    end
    step();
    wr_en = 1'b0;
    wr_en_b = 1'b0;
  endtask

  task automatic goto(input bit b, input int h, input int v, input string tag);
    int n;
    n = 0;
    while (!(int'(b ? hc_b : hc) == h && int'(b ? vc_b : vc) == v) && n < 3000) begin
      step();
      n++;
    end
    check({tag, "_reach"}, 32'(n < 3000), 1);
  endtask

  task automatic wait_fs(input bit b, output int n);
    n = 0;
    while ((b ? frame_start_b : frame_start) !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) n = -1;
  endtask

  task automatic do_swap(input bit b, input string tag, input int hold);
    int n, acks;
    if (b) swap_req_b = 1'b1;
    else   swap_req = 1'b1;
    n = 0;
    while ((b ? swap_ack_b : swap_ack) !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    check({tag, "_ack_seen"}, 32'(n < 2000), 1);
    check({tag, "_ack_hc"}, 32'(b ? hc_b : hc), 1);
    check({tag, "_ack_vc"}, 32'(b ? vc_b : vc), 8);
    step();
    check({tag, "_ack_pulse"}, 32'(b ? swap_ack_b : swap_ack), 0);
    if (hold > 0) begin
      acks = 0;
      for (int k = 0; k < hold; k++) begin
        if ((b ? swap_ack_b : swap_ack) === 1'b1) acks++;
        step();
      end
      check({tag, "_no_second_ack"}, acks, 0);
    end
    swap_req = 1'b0;
    swap_req_b = 1'b0;
    step();
  endtask

  // Output at each sample reflects the counters sampled two clk earlier.
  task automatic scan(input bit b, input string tag, input int h0, input int h1,
                      input int v0, input int v1, input logic [11:0] col);
    int n, h, v, hp1, vp1, hp2, vp2, bad_rgb, bad_sync, fr;
    logic [11:0] erg, org;
    logic ehs, evs;
    fr = b ? FR_B : FR_A;
    wait_fs(b, n);
    check({tag, "_fs_seen"}, 32'(n >= 0), 1);
    bad_rgb = 0; bad_sync = 0;
    hp1 = 0; vp1 = 0; hp2 = 0; vp2 = 0;
    for (int k = 0; k < fr; k++) begin
      h = int'(b ? hc_b : hc);
      v = int'(b ? vc_b : vc);
      if (k >= 2) begin
        erg = (hp2 >= h0 && hp2 <= h1 && vp2 >= v0 && vp2 <= v1) ? col : 12'h000;
        org = b ? {red_b, green_b, blue_b} : {red, green, blue};
        ehs = (hp2 >= 18 && hp2 < 21) ? b : ~b;
        evs = (vp2 >= 9 && vp2 < 11) ? b : ~b;
        if (org !== erg) bad_rgb++;
        if ((b ? hsync_b : hsync) !== ehs || (b ? vsync_b : vsync) !== evs) bad_sync++;
      end
      hp2 = hp1; vp2 = vp1; hp1 = h; vp1 = v;
      step();
    end
    check({tag, "_rgb_bad_px"}, bad_rgb, 0);
    check({tag, "_sync_bad_px"}, bad_sync, 0);
  endtask

  initial begin
    int n, acks;

    repeat (3) step();
    check("rst_hc", 32'(hc), 0);
    check("rst_vc", 32'(vc), 0);
    check("rst_hsync", 32'(hsync), 1);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_rgb", 32'({red, green, blue}), 0);
    check("rst_swap_ack", 32'(swap_ack), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_hsync_b", 32'(hsync_b), 0);
    check("rst_vsync_b", 32'(vsync_b), 0);
    rst = 1'b0;

    step();
    check("tick_div_hold_hc", 32'(hc), 0);
    step();
    check("tick_first_hc", 32'(hc), 1);

    wait_fs(0, n);
    check("fs_first_delay", n, 574);
    check("fs_at_hc", 32'(hc), 0);
    check("fs_at_vc", 32'(vc), 0);
    step();
    check("fs_pulse_width", 32'(frame_start), 0);
    wait_fs(0, n);
    check("fs_period", n + 1, FR_A);

    // Bank 1 is the back buffer out of reset: clear it, then swap with the request held two frames.
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) wr(0, x, y, 12'h000);
    goto(0, 0, 2, "swap1_pre");
    do_swap(0, "swap1", 2 * FR_A);

    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) wr(0, x, y, 12'h000);
    wr(0, 5, 3, 12'h0E0);
    wr(0, 8, 0, 12'h0FF);
    wr(0, 0, 4, 12'h0FF);
    do_swap(0, "swap2", 0);
    scan(0, "scale", 10, 11, 6, 7, 12'hF00);

    // Write on the exact toggle clk must land in the buffer that becomes front.
    goto(0, 0, 2, "col_pre");
    swap_req = 1'b1;
    goto(0, 0, 8, "col_line");
    step();
    wr(0, 0, 0, 12'h01C);
    check("col_ack", 32'(swap_ack), 1);
    check("col_ack_hc", 32'(hc), 1);
    swap_req = 1'b0;
    step();
    scan(0, "collide", 0, 1, 0, 1, 12'h0F0);

    goto(0, 0, 2, "rst_pre");
    swap_req = 1'b1;
    goto(0, 9, 4, "rst_point");
    rst = 1'b1;
    step();
    check("mid_rst_hc", 32'(hc), 0);
    check("mid_rst_vc", 32'(vc), 0);
    check("mid_rst_hsync", 32'(hsync), 1);
    check("mid_rst_vsync", 32'(vsync), 1);
    check("mid_rst_rgb", 32'({red, green, blue}), 0);
    check("mid_rst_ack", 32'(swap_ack), 0);
    rst = 1'b0;
    swap_req = 1'b0;
    acks = 0;
    for (int k = 0; k < 700; k++) begin
      if (swap_ack === 1'b1) acks++;
      step();
    end
    check("mid_rst_no_ack", acks, 0);
    scan(0, "post_rst_front0", 10, 11, 6, 7, 12'hF00);

    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++) wr(1, x, y, 12'h000);
    wr(1, 0, 0, 12'hABC);
    do_swap(1, "swap_b", 0);
    scan(1, "sweep", 0, 3, 0, 3, 12'hABC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
